// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Character buffer and sequencer that sits directly upstream of uart_tx.
//   Producers push characters into a synchronous FIFO at any rate. The feeder
//   pops one character at a time, presents it on to_sent, issues a one-cycle
//   flush and then follows uart_tx busy. Frames therefore go out back-to-back,
//   separated by a programmable idle gap.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active low
//   wr_data   in   character to enqueue
//   wr_en     in   enqueue strobe, accepted only while full is low
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds no entries
//   level     out  current entry count, 0..DEPTH
//   overflow  out  sticky flag: a write was dropped while full
//   ovf_clr   in   clears overflow; a drop in the same cycle takes priority
//   to_sent   out  character for uart_tx, held from pop until the frame ends
//   flush     out  one-cycle start pulse for uart_tx
//   busy      in   uart_tx frame-in-progress indication
module uart_tx_feeder #(
  parameter int DATA_WIDTH   = 7,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CLKS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] to_sent,
  output logic                  flush,
  input  logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WAIT_HI,
    WAIT_LO,
    GAP
  } state_t;

  localparam int TMR_W = $clog2(BUSY_TIMEOUT);
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       count;
  state_t                state;
  state_t                state_nxt;
  logic [TMR_W-1:0]      timer;
  logic [TMR_W-1:0]      timer_plus1;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  push;
  logic                  pop;
  logic                  flush_nxt;

  // Status flags come straight from the registered count, so they never
  // glitch on a same-cycle write or pop.
  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign level       = count;
  assign push        = wr_en && !full;
  assign timer_plus1 = timer + TMR_W'(1);

  // Storage array carries no reset; stale entries are unreachable once the
  // pointers and count return to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag. A push and a pop in the
  // same cycle cancel in the count. A write attempted while full is dropped
  // even if a pop frees a slot that same cycle, because full is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A busy level seen while idle is ignored; only the FIFO
  // occupancy decides when the next character is popped. If uart_tx never
  // acknowledges a flush, the same character is flushed again after the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (busy) begin
          state_nxt = WAIT_LO;
        end else if (timer_plus1 == TMR_LAST) begin
          state_nxt = FLUSH;
        end
      end
      WAIT_LO: begin
        if (!busy) begin
          state_nxt = (GAP_CLKS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode. The flush pulse is registered from the FLUSH state, so it
  // appears on the wire one cycle after the sequencer enters FLUSH.
  always_comb begin
    pop       = (state == IDLE) && !empty;
    flush_nxt = (state == FLUSH);
  end

  // Registered outputs and the retry and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_sent <= '0;
      flush   <= 1'b0;
      timer   <= '0;
      gap_cnt <= '0;
    end else begin
      flush <= flush_nxt;
      if (pop) begin
        to_sent <= mem[rd_ptr];
      end
      if (state == FLUSH) begin
        timer <= '0;
      end else if (state == WAIT_HI && !busy) begin
        timer <= timer_plus1;
      end
      if (state == WAIT_LO) begin
        gap_cnt <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder. A small busy responder stands in for
//   uart_tx. Accepted characters are queued as expected output, and a monitor
//   compares to_sent against the queue on every flush pulse.
module tb_uart_tx_feeder;

  localparam int DW    = 7;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BT    = 16;
  localparam int GAP   = 1;
  localparam int FRAME = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          ovf_clr;
  logic [DW-1:0] to_sent;
  logic          flush;
  logic          busy;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int flush_cnt = 0;

  // Busy source: 0 = responder, 1 = stuck high, 2 = stuck low.
  int   busy_mode = 0;
  logic resp_busy = 1'b0;
  int   resp_cnt = 0;

  logic [DW-1:0] exp_q[$];
  bit   mon_en = 1'b1;
  bit   gap_chk = 1'b0;
  bit   fall_valid = 1'b0;
  int   fall_cyc = 0;
  logic busy_d = 1'b0;

  uart_tx_feeder #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .BUSY_TIMEOUT(BT),
    .GAP_CLKS    (GAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow),
    .ovf_clr (ovf_clr),
    .to_sent (to_sent),
    .flush   (flush),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for uart_tx: a flush starts a frame that keeps busy high for
  // FRAME cycles.
  always @(posedge clk) begin
    if (resp_busy) begin
      if (resp_cnt == 1) resp_busy <= 1'b0;
      resp_cnt <= resp_cnt - 1;
    end else if (flush) begin
      resp_busy <= 1'b1;
      resp_cnt  <= FRAME;
    end
  end

  assign busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : resp_busy;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every flush pulse must carry the oldest outstanding character.
  // Busy falling edges are recorded so that the idle gap can be measured.
  always @(negedge clk) begin
    if (busy_d && !busy) begin
      fall_valid = 1'b1;
      fall_cyc   = cyc;
    end
    busy_d = busy;
    if (rst_n && flush) begin
      flush_cnt++;
      if (mon_en) begin
        if (exp_q.size() == 0) checkOutput("unexpected_flush", 32'd1, 32'd0);
        else checkOutput("to_sent_order", 32'(to_sent), 32'(exp_q.pop_front()));
        if (gap_chk && fall_valid) checkOutput("flush_gap", 32'(cyc - fall_cyc), 32'(GAP + 3));
        fall_valid = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input bit accept);
    wr_data = d;
    wr_en   = 1'b1;
    if (accept) exp_q.push_back(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_to_sent", 32'(to_sent), 32'd0);
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
  endtask

  task automatic waitDrain(input int budget);
    int k = 0;
    while (!(empty && exp_q.size() == 0 && !busy) && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput("drain_timeout", 32'(k >= budget), 32'd0);
    tick(6);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int base;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    ovf_clr = 1'b0;
    tick(2);
    checkResetValues();
    rst_n = 1'b1;
    tick(2);

    // Single character: latency and exactly one flush pulse.
    $display("[TB] single character");
    base = flush_cnt;
    applyStimulus(7'h73, 1'b1);
    checkOutput("t1_empty_after_write", 32'(empty), 32'd0);
    checkOutput("t1_to_sent_not_yet", 32'(to_sent), 32'd0);
    tick(1);
    checkOutput("t1_to_sent", 32'(to_sent), 32'h73);
    checkOutput("t1_flush_not_yet", 32'(flush), 32'd0);
    tick(1);
    checkOutput("t1_flush_high", 32'(flush), 32'd1);
    tick(1);
    checkOutput("t1_flush_low", 32'(flush), 32'd0);
    waitDrain(200);
    checkOutput("t1_flush_count", 32'(flush_cnt - base), 32'd1);
    checkOutput("t1_level", 32'(level), 32'd0);

    // Burst of 17 characters: one pop leaves the FIFO exactly full.
    $display("[TB] burst");
    gap_chk    = 1'b1;
    fall_valid = 1'b0;
    for (int i = 0; i < 17; i++) applyStimulus(DW'(8'h41 + i), 1'b1);
    checkOutput("t2_full", 32'(full), 32'd1);
    checkOutput("t2_level", 32'(level), 32'd16);
    checkOutput("t2_overflow", 32'(overflow), 32'd0);
    waitDrain(1200);
    gap_chk = 1'b0;

    // Busy stuck high: overflow set, cleared, and a coincident drop wins.
    $display("[TB] overflow");
    busy_mode = 1;
    applyStimulus(7'h10, 1'b1);
    tick(6);
    for (int i = 0; i < 17; i++) applyStimulus(DW'(8'h11 + i), i < 16);
    checkOutput("t3_level", 32'(level), 32'd16);
    checkOutput("t3_full", 32'(full), 32'd1);
    checkOutput("t3_overflow", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checkOutput("t3_ovf_cleared", 32'(overflow), 32'd0);
    wr_data = 7'h7F;
    wr_en   = 1'b1;
    ovf_clr = 1'b1;
    tick(1);
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    checkOutput("t3_drop_beats_clr", 32'(overflow), 32'd1);
    checkOutput("t3_level_kept", 32'(level), 32'd16);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    busy_mode = 0;
    waitDrain(1200);

    // No uart_tx: the same character is re-flushed every BT cycles.
    $display("[TB] timeout retry");
    mon_en    = 1'b0;
    busy_mode = 2;
    applyStimulus(7'h2A, 1'b0);
    k = 0;
    while (!flush && k < 20) begin
      tick(1);
      k++;
    end
    checkOutput("t4_first_flush", 32'(flush), 32'd1);
    for (int r = 0; r < 3; r++) begin
      tick(1);
      k = 1;
      while (!flush && k < 40) begin
        tick(1);
        k++;
      end
      checkOutput("t4_retry_period", 32'(k), 32'(BT));
      checkOutput("t4_to_sent_held", 32'(to_sent), 32'h2A);
      checkOutput("t4_level", 32'(level), 32'd0);
    end
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    busy_mode = 0;
    mon_en    = 1'b1;
    waitDrain(200);

    // Write and pop in the same cycle at level 5, then pointer wrap.
    $display("[TB] push/pop and wrap");
    busy_mode = 1;
    applyStimulus(7'h60, 1'b1);
    tick(30);
    for (int i = 0; i < 5; i++) applyStimulus(DW'(8'h61 + i), 1'b1);
    checkOutput("t5_level5", 32'(level), 32'd5);
    @(negedge clk);
    busy_mode = 2;
    tick(2);
    checkOutput("t5_level_before_pop", 32'(level), 32'd5);
    wr_data = 7'h66;
    wr_en   = 1'b1;
    exp_q.push_back(7'h66);
    tick(1);
    wr_en = 1'b0;
    checkOutput("t5_push_pop_level", 32'(level), 32'd5);
    checkOutput("t5_popped", 32'(to_sent), 32'h61);
    busy_mode = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(DW'(8'h30 + i), 1'b1);
      tick(20);
    end
    waitDrain(1500);
    checkOutput("t5_no_overflow", 32'(overflow), 32'd0);

    // Reset while a flush pulse is on the wire.
    $display("[TB] reset during flush");
    applyStimulus(7'h55, 1'b1);
    tick(2);
    checkOutput("t6_flush_before_rst", 32'(flush), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("t6_flush_dropped", 32'(flush), 32'd0);
    tick(2);
    rst_n = 1'b1;
    waitDrain(200);

    // Reset mid-frame with three characters still queued.
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(DW'(8'h01 + i), 1'b1);
    tick(5);
    checkOutput("t7_level3", 32'(level), 32'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkResetValues();
    tick(2);
    rst_n = 1'b1;
    base = flush_cnt;
    tick(40);
    checkOutput("t7_no_flush_after_rst", 32'(flush_cnt - base), 32'd0);
    checkOutput("t7_empty", 32'(empty), 32'd1);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
